cpu_control_fsm: RTL and testbench
==================================

// Module: cpu_control_fsm
// PURPOSE
// Multi-cycle fetch/decode/execute/writeback sequencer for the 8-bit CPU; sits directly upstream of
// the 8x8 register file. Fetches 16-bit instructions, drives the register file's destination/operand
// addresses and reg_write strobe, selects the write-back source and ALU op, and owns the 8-bit PC.
// PARAMETERS
// PC_RESET  8'h00  PC value loaded on reset
// PORTS
// clk            in   1   system clock; all state updates on rising edge
// rst_n          in   1   synchronous active-low reset
// imem_req       out  1   fetch request; high for every FETCH cycle
// imem_addr      out  8   fetch address (= pc)
// imem_valid     in   1   instruction word valid this cycle
// imem_data      in   16  instruction word
// rs1_data       in   8   register-file data_out1 (used by BEQZ)
// reg_dst        out  3   register-file destination address (instr[11:9])
// reg_src1       out  3   register-file operand-1 address (instr[8:6])
// reg_src2       out  3   register-file operand-2 address (instr[5:3])
// reg_write      out  1   register-file write strobe, one cycle in WRITEBACK only
// wb_sel         out  2   write-back mux: 00 ALU, 01 immediate, 10 rs1 data
// alu_op         out  3   000 ADD 001 SUB 010 AND 011 OR 100 XOR
// imm            out  8   immediate (instr[7:0])
// pc             out  8   program counter
// halted         out  1   high while in HALT
// BEHAVIOUR
// - Encoding: op=instr[15:12]. 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 LDI rd<=imm, 7 MOV rd<=rs1,
//   8 JMP pc<=imm, 9 BEQZ (rs1==0 ? pc<=imm : pc+1), F HALT; A-E decode as NOP.
// - Reset (rst_n low at clk edge): state=FETCH, pc=PC_RESET, instr reg=16'h0000, reg_write=0,
//   imem_req=0 in the reset cycle, wb_sel=00, alu_op=000, halted=0. Reset wins over all events and
//   aborts any instruction in flight; no write is issued for an aborted instruction.
// - States: FETCH -> DECODE -> EXECUTE -> WRITEBACK -> FETCH; HALT terminal until reset.
// - FETCH: imem_req=1, imem_addr=pc. Stay while imem_valid=0 (unbounded wait). On imem_valid=1
//   latch imem_data into instr reg, go DECODE. imem_valid outside FETCH is ignored.
// - reg_dst/reg_src1/reg_src2/imm are decoded combinationally from the latched instr reg and stable
//   from DECODE through WRITEBACK; register file reads are asynchronous, so rs1_data valid in EXECUTE.
// - DECODE: alu_op, wb_sel registered from opcode. HALT opcode -> HALT state (pc not advanced).
// - EXECUTE: BEQZ samples rs1_data; JMP/BEQZ compute next pc into a next-pc register.
// - WRITEBACK: reg_write=1 for exactly this one cycle when op in {1..7}; 0 otherwise. pc updated at
//   end of this cycle: pc+1 (mod 256, 8'hFF wraps to 8'h00) or branch/jump target. -> FETCH.
// - Minimum latency 4 cycles/instruction (imem_valid in first FETCH cycle); each FETCH wait adds one.
// - R0 is an ordinary writable register; rd==rs1 permitted (read-before-write in same instruction).
// - HALT: halted=1, imem_req=0, reg_write=0, all other outputs hold.
// TESTING
// - Reset: rst_n=0 two cycles -> pc=00, reg_write=0, imem_req=0, halted=0; first FETCH next cycle.
// - LDI r3,8'h5A with imem_valid immediate -> 4th cycle reg_write=1, reg_dst=3, wb_sel=01, imm=5A; pc=01.
// - ADD r1,r2,r4 with imem_valid delayed 3 cycles -> imem_req held 4 cycles, alu_op=000, one write, pc+1.
// - BEQZ r5,8'h40: rs1_data=0 -> pc=40, reg_write never 1; rs1_data=07 -> pc=old+1.
// - pc=FF executing NOP -> pc=00; JMP 8'h10 -> pc=10; HALT -> halted=1, pc frozen, no imem_req.
// - rst_n low during WRITEBACK of ADD -> reg_write=0 that cycle, pc=PC_RESET, state FETCH.

Source files
------------

// File: rtl/cpu_control_fsm_if.sv
// rtl/cpu_control_fsm_if.sv - instruction fetch handshake between sequencer and instruction memory
interface cpu_control_fsm_if;
  logic        req;
  logic [7:0]  addr;
  logic        valid;
  logic [15:0] data;

  modport master (output req, output addr, input valid, input data);
  modport slave  (input req, input addr, output valid, output data);
endinterface

// File: rtl/cpu_control_fsm.sv
// rtl/cpu_control_fsm.sv - fetch/decode/execute/writeback sequencer owning the PC
// and driving register-file addresses, write strobe, write-back select and ALU op.
module cpu_control_fsm #(
  parameter logic [7:0] PC_RESET = 8'h00
) (
  input  logic                     clk,
  input  logic                     rst_n,
  cpu_control_fsm_if.master        imem,
  input  logic [7:0]               rs1_data,
  output logic [2:0]               reg_dst,
  output logic [2:0]               reg_src1,
  output logic [2:0]               reg_src2,
  output logic                     reg_write,
  output logic [1:0]               wb_sel,
  output logic [2:0]               alu_op,
  output logic [7:0]               imm,
  output logic [7:0]               pc,
  output logic                     halted
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_WRITEBACK = 3'd3,
    S_HALT      = 3'd4
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_LDI  = 4'h6;
  localparam logic [3:0] OP_MOV  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_BEQZ = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t      state, state_nx;
  logic [15:0] instr;
  logic [7:0]  next_pc;
  logic [3:0]  op;
  logic [2:0]  alu_op_dec;
  logic [1:0]  wb_sel_dec;
  logic        writes_rd;
  logic [7:0]  target_pc;

  assign op       = instr[15:12];
  assign reg_dst  = instr[11:9];
  assign reg_src1 = instr[8:6];
  assign reg_src2 = instr[5:3];
  assign imm      = instr[7:0];

  // Gating with rst_n keeps the strobes quiet during the reset cycle itself,
  // so an instruction aborted in WRITEBACK never writes.
  assign imem.req  = rst_n && (state == S_FETCH);
  assign imem.addr = pc;
  assign reg_write = rst_n && (state == S_WRITEBACK) && writes_rd;
  assign halted    = (state == S_HALT);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_FETCH:     if (imem.valid) state_nx = S_DECODE;
      S_DECODE:    state_nx = (op == OP_HALT) ? S_HALT : S_EXECUTE;
      S_EXECUTE:   state_nx = S_WRITEBACK;
      S_WRITEBACK: state_nx = S_FETCH;
      S_HALT:      state_nx = S_HALT;
      default:     state_nx = S_FETCH;
    endcase
  end

  always_comb begin
    alu_op_dec = 3'b000;
    wb_sel_dec = 2'b00;
    writes_rd  = 1'b0;
    target_pc  = pc + 8'd1;
    case (op)
      OP_ADD:  begin alu_op_dec = 3'b000; writes_rd = 1'b1; end
      OP_SUB:  begin alu_op_dec = 3'b001; writes_rd = 1'b1; end
      OP_AND:  begin alu_op_dec = 3'b010; writes_rd = 1'b1; end
      OP_OR:   begin alu_op_dec = 3'b011; writes_rd = 1'b1; end
      OP_XOR:  begin alu_op_dec = 3'b100; writes_rd = 1'b1; end
      OP_LDI:  begin wb_sel_dec = 2'b01;  writes_rd = 1'b1; end
      OP_MOV:  begin wb_sel_dec = 2'b10;  writes_rd = 1'b1; end
      OP_JMP:  target_pc = instr[7:0];
      OP_BEQZ: if (rs1_data == 8'h00) target_pc = instr[7:0];
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc      <= PC_RESET;
      instr   <= 16'h0000;
      next_pc <= PC_RESET;
      wb_sel  <= 2'b00;
      alu_op  <= 3'b000;
    end else begin
      case (state)
        S_FETCH:     if (imem.valid) instr <= imem.data;
        S_DECODE:    begin
          alu_op <= alu_op_dec;
          wb_sel <= wb_sel_dec;
        end
        // rs1_data is only trusted here, after the async regfile read has settled.
        S_EXECUTE:   next_pc <= target_pc;
        S_WRITEBACK: pc <= next_pc;
        default:     ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// tb/tb_cpu_control_fsm.sv - directed bench for cpu_control_fsm
module tb_cpu_control_fsm;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rs1_data;
  logic [2:0] reg_dst, reg_src1, reg_src2, alu_op;
  logic       reg_write, halted;
  logic [1:0] wb_sel;
  logic [7:0] imm, pc;

  cpu_control_fsm_if imem ();

  cpu_control_fsm #(.PC_RESET(8'h00)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .imem     (imem),
    .rs1_data (rs1_data),
    .reg_dst  (reg_dst),
    .reg_src1 (reg_src1),
    .reg_src2 (reg_src2),
    .reg_write(reg_write),
    .wb_sel   (wb_sel),
    .alu_op   (alu_op),
    .imm      (imm),
    .pc       (pc),
    .halted   (halted)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int req_cyc, wr_cnt;
  logic       wb_rw;
  logic [2:0] wb_dst, wb_src1, wb_src2, wb_alu;
  logic [1:0] wb_wsel;
  logic [7:0] wb_imm, pc_after;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Starts in a FETCH cycle, ends at the negedge of the following FETCH.
  task automatic exec(input logic [15:0] ins, input int dly, input logic [7:0] rs1v);
    req_cyc = 0;
    wr_cnt  = 0;
    imem.valid = 1'b0;
    for (int i = 0; i < dly; i++) begin
      if (imem.req) req_cyc++;
      @(negedge clk);
    end
    imem.valid = 1'b1;
    imem.data  = ins;
    if (imem.req) req_cyc++;
    @(negedge clk);
    imem.data = 16'hFFFF;
    rs1_data  = rs1v;
    for (int c = 0; c < 3; c++) begin
      if (imem.req) req_cyc++;
      if (reg_write) wr_cnt++;
      if (c == 2) begin
        wb_rw   = reg_write;
        wb_dst  = reg_dst;
        wb_src1 = reg_src1;
        wb_src2 = reg_src2;
        wb_alu  = alu_op;
        wb_wsel = wb_sel;
        wb_imm  = imm;
      end
      @(negedge clk);
    end
    imem.valid = 1'b0;
    pc_after = pc;
  endtask

  initial begin
    rst_n = 1'b0;
    imem.valid = 1'b0;
    imem.data = 16'h0000;
    rs1_data = 8'h00;

    @(negedge clk);
    check("rst_pc", 16'(pc), 16'h00);
    check("rst_wr", 16'(reg_write), 16'h0);
    check("rst_req", 16'(imem.req), 16'h0);
    check("rst_halt", 16'(halted), 16'h0);
    @(negedge clk);
    check("rst_req2", 16'(imem.req), 16'h0);
    rst_n = 1'b1;
    #1;
    check("first_fetch_req", 16'(imem.req), 16'h1);
    check("first_fetch_addr", 16'(imem.addr), 16'h00);

    exec(16'h665A, 0, 8'h00);
    check("ldi_wr", 16'(wb_rw), 16'h1);
    check("ldi_cnt", 16'(wr_cnt), 16'd1);
    check("ldi_dst", 16'(wb_dst), 16'h3);
    check("ldi_sel", 16'(wb_wsel), 16'h1);
    check("ldi_imm", 16'(wb_imm), 16'h5A);
    check("ldi_req", 16'(req_cyc), 16'd1);
    check("ldi_pc", 16'(pc_after), 16'h01);

    exec(16'h12A0, 3, 8'h00);
    check("add_req", 16'(req_cyc), 16'd4);
    check("add_alu", 16'(wb_alu), 16'h0);
    check("add_dst", 16'(wb_dst), 16'h1);
    check("add_src1", 16'(wb_src1), 16'h2);
    check("add_src2", 16'(wb_src2), 16'h4);
    check("add_cnt", 16'(wr_cnt), 16'd1);
    check("add_pc", 16'(pc_after), 16'h02);

    exec(16'h9140, 0, 8'h00);
    check("beqz_t_src1", 16'(wb_src1), 16'h5);
    check("beqz_t_cnt", 16'(wr_cnt), 16'd0);
    check("beqz_t_pc", 16'(pc_after), 16'h40);

    exec(16'h9140, 0, 8'h07);
    check("beqz_n_cnt", 16'(wr_cnt), 16'd0);
    check("beqz_n_pc", 16'(pc_after), 16'h41);

    exec(16'h80FF, 0, 8'h00);
    check("jmp_ff_pc", 16'(pc_after), 16'hFF);
    exec(16'h0000, 0, 8'h00);
    check("nop_wrap_pc", 16'(pc_after), 16'h00);
    check("nop_cnt", 16'(wr_cnt), 16'd0);

    exec(16'h2FC0, 1, 8'h00);
    check("sub_alu", 16'(wb_alu), 16'h1);
    check("sub_dst", 16'(wb_dst), 16'h7);
    check("sub_src1", 16'(wb_src1), 16'h7);
    check("sub_cnt", 16'(wr_cnt), 16'd1);
    check("sub_pc", 16'(pc_after), 16'h01);

    exec(16'h5000, 0, 8'h00);
    check("xor_alu", 16'(wb_alu), 16'h4);
    check("xor_sel", 16'(wb_wsel), 16'h0);
    check("xor_pc", 16'(pc_after), 16'h02);

    exec(16'h74C0, 0, 8'h00);
    check("mov_sel", 16'(wb_wsel), 16'h2);
    check("mov_dst", 16'(wb_dst), 16'h2);
    check("mov_src1", 16'(wb_src1), 16'h3);
    check("mov_cnt", 16'(wr_cnt), 16'd1);
    check("mov_pc", 16'(pc_after), 16'h03);

    exec(16'hA123, 0, 8'h00);
    check("opa_cnt", 16'(wr_cnt), 16'd0);
    check("opa_pc", 16'(pc_after), 16'h04);

    exec(16'h8010, 0, 8'h00);
    check("jmp_10_pc", 16'(pc_after), 16'h10);

    // Reset asserted partway into the WRITEBACK cycle of an ADD.
    imem.valid = 1'b1;
    imem.data  = 16'h12A0;
    @(negedge clk);
    imem.valid = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("abort_wr", 16'(reg_write), 16'h0);
    @(posedge clk);
    #1;
    check("abort_pc", 16'(pc), 16'h00);
    check("abort_req", 16'(imem.req), 16'h0);
    check("abort_wr2", 16'(reg_write), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("abort_fetch_req", 16'(imem.req), 16'h1);
    check("abort_fetch_addr", 16'(imem.addr), 16'h00);

    imem.valid = 1'b1;
    imem.data  = 16'hF000;
    @(negedge clk);
    imem.data = 16'h665A;
    @(negedge clk);
    check("halt_flag", 16'(halted), 16'h1);
    check("halt_req", 16'(imem.req), 16'h0);
    check("halt_pc", 16'(pc), 16'h00);
    req_cyc = 0;
    wr_cnt  = 0;
    for (int i = 0; i < 6; i++) begin
      if (imem.req) req_cyc++;
      if (reg_write) wr_cnt++;
      @(negedge clk);
    end
    check("halt_req_cnt", 16'(req_cyc), 16'd0);
    check("halt_wr_cnt", 16'(wr_cnt), 16'd0);
    check("halt_pc_frozen", 16'(pc), 16'h00);
    check("halt_still", 16'(halted), 16'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
